// File: rtl/alu_seq.sv
// Sequential ALU. Logic, arithmetic and shift ops finish on the start edge.
// MUL (shift-add) and DIV (restoring) iterate one bit per clock.
module alu_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_acc,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] acc,
    output logic [W-1:0] acc_hi,
    output logic         co,
    output logic         z,
    output logic         neg
);
    // state | meaning
    // IDLE  | accepts start; single-cycle ops and divide-by-zero complete here
    // ITER  | MUL/DIV in progress, one bit per clock, start ignored

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_ASR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;

    typedef enum logic {IDLE, ITER} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          is_div;
    logic [W-1:0]  opnd;
    logic [W-1:0]  work_hi;
    logic [W-1:0]  work_lo;

    logic [W:0]    alu_res;
    logic [W:0]    mul_sum;
    logic [W:0]    div_shift;
    logic [W:0]    div_diff;
    logic [W-1:0]  step_hi;
    logic [W-1:0]  step_lo;

    // Bit W of alu_res carries co for the single-cycle ops.
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = {1'b0, in_acc} + {1'b0, in_a} + {{W{1'b0}}, ci};
            OP_SUB:  alu_res = {1'b0, in_acc} + {1'b0, ~in_a} + {{W{1'b0}}, 1'b1};
            OP_AND:  alu_res = {1'b0, in_acc & in_a};
            OP_OR:   alu_res = {1'b0, in_acc | in_a};
            OP_XOR:  alu_res = {1'b0, in_acc ^ in_a};
            OP_SHL:  alu_res = {in_acc[W-1], in_acc[W-2:0], 1'b0};
            OP_SHR:  alu_res = {in_acc[0], 1'b0, in_acc[W-1:1]};
            OP_ASR:  alu_res = {in_acc[0], in_acc[W-1], in_acc[W-1:1]};
            default: alu_res = '0;
        endcase
    end

    // MUL: {work_hi,work_lo} holds partial product and remaining multiplier bits.
    // DIV: work_hi is the partial remainder, work_lo shifts dividend out / quotient in.
    always_comb begin
        step_hi   = work_hi;
        step_lo   = work_lo;
        mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : {(W+1){1'b0}});
        div_shift = {work_hi, work_lo[W-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (is_div) begin
            if (div_diff[W]) begin
                step_hi = div_shift[W-1:0];
                step_lo = {work_lo[W-2:0], 1'b0};
            end else begin
                step_hi = div_diff[W-1:0];
                step_lo = {work_lo[W-2:0], 1'b1};
            end
        end else begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], work_lo[W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            is_div  <= 1'b0;
            opnd    <= '0;
            work_hi <= '0;
            work_lo <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            acc     <= '0;
            acc_hi  <= '0;
            co      <= 1'b0;
            z       <= 1'b0;
            neg     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_ADD, OP_SUB, OP_AND, OP_OR,
                            OP_XOR, OP_SHL, OP_SHR, OP_ASR: begin
                                acc    <= alu_res[W-1:0];
                                acc_hi <= '0;
                                co     <= alu_res[W];
                                z      <= (alu_res[W-1:0] == '0);
                                neg    <= alu_res[W-1];
                                done   <= 1'b1;
                            end
                            OP_MUL: begin
                                is_div  <= 1'b0;
                                opnd    <= in_acc;
                                work_hi <= '0;
                                work_lo <= in_a;
                                cnt     <= '0;
                                busy    <= 1'b1;
                                state   <= ITER;
                            end
                            OP_DIV: begin
                                if (in_a == '0) begin
                                    acc    <= '1;
                                    acc_hi <= in_acc;
                                    co     <= 1'b1;
                                    z      <= 1'b0;
                                    neg    <= 1'b1;
                                    done   <= 1'b1;
                                end else begin
                                    is_div  <= 1'b1;
                                    opnd    <= in_a;
                                    work_hi <= '0;
                                    work_lo <= in_acc;
                                    cnt     <= '0;
                                    busy    <= 1'b1;
                                    state   <= ITER;
                                end
                            end
                            default: done <= 1'b1;
                        endcase
                    end
                end
                ITER: begin
                    work_hi <= step_hi;
                    work_lo <= step_lo;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        acc    <= step_lo;
                        acc_hi <= step_hi;
                        co     <= 1'b0;
                        z      <= (step_lo == '0);
                        neg    <= step_lo[W-1];
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        cnt    <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes hand-computed results,
// a negedge monitor pops them on each done pulse and checks hold otherwise.
module tb_alu_seq;
    localparam int W = 8;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_ASR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_acc;
    logic         ci;
    logic         busy;
    logic         done;
    logic [W-1:0] acc;
    logic [W-1:0] acc_hi;
    logic         co;
    logic         z;
    logic         neg;

    alu_seq #(.W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .in_a(in_a),
        .in_acc(in_acc), .ci(ci), .busy(busy), .done(done), .acc(acc),
        .acc_hi(acc_hi), .co(co), .z(z), .neg(neg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] acc;
        logic [W-1:0] hi;
        logic         co;
        logic         z;
        logic         neg;
        int           at;
        string        name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic [2*W+2:0] prev = '0;
    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0] l_acc = '0;
    logic [W-1:0] l_hi  = '0;
    logic         l_co  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Called just after a rising edge; the next edge is the start edge.
    task automatic issue(input string name, input logic [3:0] o, input logic [W-1:0] b,
                         input logic [W-1:0] a, input logic c, input logic [W-1:0] e_acc,
                         input logic [W-1:0] e_hi, input logic e_co, input int lat);
        exp_t e;
        e.acc  = e_acc;
        e.hi   = e_hi;
        e.co   = e_co;
        e.z    = (e_acc == '0);
        e.neg  = e_acc[W-1];
        e.at   = cyc + 1 + lat;
        e.name = name;
        sb.push_back(e);
        l_acc = e_acc;
        l_hi  = e_hi;
        l_co  = e_co;
        op = o; in_acc = b; in_a = a; ci = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Checks busy over the iteration; optionally pokes start and scrambles inputs.
    task automatic watch(input string name, input bit poke);
        for (int i = 0; i < W; i++) begin
            chk({name, "_busy"}, 32'(busy), 32'd1);
            if (poke && (i == 2 || i == W - 1)) begin
                op = OP_ADD; in_a = 8'h01; in_acc = 8'h01; ci = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({name, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk); #1;
            t++;
        end
        chk({name, "_drain"}, 32'(sb.size()), 32'd0);
        sb.delete();
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            prev = {acc, acc_hi, co, z, neg};
        end else if (done) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_acc"},    32'(acc),    32'(mon_e.acc));
                chk({mon_e.name, "_acc_hi"}, 32'(acc_hi), 32'(mon_e.hi));
                chk({mon_e.name, "_co"},     32'(co),     32'(mon_e.co));
                chk({mon_e.name, "_z"},      32'(z),      32'(mon_e.z));
                chk({mon_e.name, "_neg"},    32'(neg),    32'(mon_e.neg));
                chk({mon_e.name, "_cycle"},  32'(cyc),    32'(mon_e.at));
            end
            prev = {acc, acc_hi, co, z, neg};
        end else begin
            chk("hold", 32'({acc, acc_hi, co, z, neg}), 32'(prev));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start = 1'b0; op = '0; in_a = '0; in_acc = '0; ci = 1'b0;
        @(posedge clk); #1;
        chk("rst_acc",    32'(acc),    32'd0);
        chk("rst_acc_hi", 32'(acc_hi), 32'd0);
        chk("rst_flags",  32'({co, z, neg}), 32'd0);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        issue("add_a",  OP_ADD, 8'h18, 8'h10, 1'b1, 8'h29, 8'h00, 1'b0, 0);
        issue("add_b",  OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 0);
        issue("sub_a",  OP_SUB, 8'h05, 8'h06, 1'b0, 8'hFF, 8'h00, 1'b0, 0);
        issue("shl",    OP_SHL, 8'h81, 8'h00, 1'b1, 8'h02, 8'h00, 1'b1, 0);
        issue("asr",    OP_ASR, 8'h80, 8'h00, 1'b0, 8'hC0, 8'h00, 1'b0, 0);
        issue("shr",    OP_SHR, 8'h01, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 0);
        issue("and",    OP_AND, 8'hF0, 8'h3C, 1'b1, 8'h30, 8'h00, 1'b0, 0);
        issue("or",     OP_OR,  8'hF0, 8'h0C, 1'b0, 8'hFC, 8'h00, 1'b0, 0);
        issue("xor",    OP_XOR, 8'hAA, 8'hFF, 1'b0, 8'h55, 8'h00, 1'b0, 0);
        issue("sub_b",  OP_SUB, 8'h10, 8'h01, 1'b1, 8'h0F, 8'h00, 1'b1, 0);
        issue("inv_a",  4'hA,   8'h33, 8'h44, 1'b0, l_acc, l_hi,  l_co, 0);
        drain("single");

        issue("mul_ff", OP_MUL, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 1'b0, W);
        watch("mul_ff", 1'b1);
        drain("mul_ff");

        issue("add_z",  OP_ADD, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 0);
        issue("div_a",  OP_DIV, 8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0, W);
        watch("div_a", 1'b1);
        drain("div_a");

        issue("div_0",  OP_DIV, 8'd100, 8'd0, 1'b0, 8'hFF, 8'd100, 1'b1, 0);
        chk("div_0_busy", 32'(busy), 32'd0);
        issue("inv_b",  4'hF,   8'h01, 8'h02, 1'b1, l_acc, l_hi,  l_co, 0);
        issue("mul_b",  OP_MUL, 8'h0D, 8'h0B, 1'b0, 8'h8F, 8'h00, 1'b0, W);
        watch("mul_b", 1'b0);
        issue("div_b",  OP_DIV, 8'h07, 8'h09, 1'b0, 8'h00, 8'h07, 1'b0, W);
        watch("div_b", 1'b0);
        issue("mul_z",  OP_MUL, 8'h00, 8'h05, 1'b0, 8'h00, 8'h00, 1'b0, W);
        watch("mul_z", 1'b0);
        drain("multi");

        issue("mul_abort", OP_MUL, 8'h12, 8'h34, 1'b0, 8'hA8, 8'h03, 1'b0, W);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_acc",    32'(acc),    32'd0);
        chk("abort_acc_hi", 32'(acc_hi), 32'd0);
        chk("abort_flags",  32'({co, z, neg}), 32'd0);
        chk("abort_busy",   32'(busy),   32'd0);
        chk("abort_done",   32'(done),   32'd0);
        sb.delete();
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        issue("add_post", OP_ADD, 8'h01, 8'h01, 1'b0, 8'h02, 8'h00, 1'b0, 0);
        drain("post_reset");
        repeat (12) @(posedge clk);
        #1;
        chk("final_queue", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter W, default 8, datapath width in bits; legal range 4..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 op  input  4  opcode: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SHL=5, SHR=6, ASR=7, MUL=8, DIV=9; 10-15 invalid.
REQ-006 in_a  input  W  operand A (addend, subtrahend, multiplier, divisor).
REQ-007 in_acc  input  W  operand B (augend, minuend, shift source, multiplicand, dividend).
REQ-008 ci  input  1  carry-in; used by ADD only.
REQ-009 busy  output  1  multi-cycle operation in progress.
REQ-010 done  output  1  one-cycle pulse; result outputs valid and updated.
REQ-011 acc  output  W  primary result / product low half / quotient.
REQ-012 acc_hi  output  W  product high half / remainder; 0 for single-cycle ops.
REQ-013 co  output  1  carry/shift-out/error flag.
REQ-014 z  output  1  acc == 0.
REQ-015 neg  output  1  acc[W-1].

Function
REQ-016 States IDLE and ITER only; busy=1 exactly in ITER.
REQ-017 All outputs registered; acc, acc_hi, co, z, neg change only on an edge where done is set, and hold otherwise.
REQ-018 Single-cycle ops (0-7): start=1 in IDLE at edge k -> results written and done=1 at edge k, done=0 at edge k+1; state stays IDLE.
REQ-019 ADD: {co,acc} = in_acc + in_a + ci, W+1-bit sum.
REQ-020 SUB: {co,acc} = in_acc + ~in_a + 1; co=1 means no borrow.
REQ-021 AND/OR/XOR: bitwise on in_acc, in_a; co=0.
REQ-022 SHL: acc = in_acc<<1, lsb 0, co = in_acc[W-1]; SHR: zero fill, co = in_acc[0]; ASR: msb replicated, co = in_acc[0].
REQ-023 MUL: unsigned shift-add, one partial product per cycle; start at edge k -> ITER, busy=1 from edge k; final iteration at edge k+W writes {acc_hi,acc} = in_acc*in_a (2W bits), co=0, done=1, busy=0, state IDLE.
REQ-024 DIV: unsigned restoring, one quotient bit per cycle, same timing as MUL; acc = quotient, acc_hi = remainder, co=0.
REQ-025 DIV with in_a=0: no ITER; at edge k acc = all ones, acc_hi = in_acc, co=1, done=1.
REQ-026 Operands, op latched at start; input changes during ITER have no effect.
REQ-027 start while busy=1 ignored, no queuing; start on the edge busy falls also ignored (busy sampled pre-edge).
REQ-028 Back-to-back single-cycle starts on consecutive edges each produce their own done pulse.
REQ-029 Invalid opcode: outputs hold, done=1 for one cycle, state IDLE.
REQ-030 z, neg computed from the new acc value written on the same edge.

Reset
REQ-031 reset=0 immediately (asynchronously) forces state IDLE, iteration counter 0, busy=0, done=0, acc=0, acc_hi=0, co=0, z=0, neg=0.
REQ-032 reset during ITER aborts the operation; no done pulse is produced for it.
REQ-033 First start honoured on the first rising edge after reset returns high.

Verification (W=8)
REQ-034 ADD in_acc=0x18, in_a=0x10, ci=1 -> next cycle acc=0x29, co=0, z=0, neg=0, done one cycle.
REQ-035 ADD 0xFF+0x01, ci=0 -> acc=0x00, co=1, z=1; SUB 0x05-0x06 -> acc=0xFF, co=0, neg=1.
REQ-036 SHL 0x81 -> acc=0x02, co=1; ASR 0x80 -> acc=0xC0, co=0; SHR 0x01 -> acc=0x00, co=1, z=1.
REQ-037 MUL 0xFF*0xFF -> busy exactly 8 cycles, done at edge k+8, acc_hi=0xFE, acc=0x01; start with ADD pulsed mid-operation ignored (no extra done).
REQ-038 DIV 100/7 -> acc=14, acc_hi=2, co=0 after 8 cycles; DIV 100/0 -> acc=0xFF, acc_hi=100, co=1, done after 1 cycle.
REQ-039 reset low at cycle 3 of MUL -> all outputs 0 immediately, no done; after release, ADD 1+1 -> acc=0x02.
